// File: rtl/bsg_mesh_router_output_port_pkg.sv
// Shared router package slice: direction encoding, per-output legal-input
// masks for each routing configuration, and small sizing helpers.
package bsg_mesh_router_output_port_pkg;

  typedef enum logic [3:0] {
    P  = 4'd0,
    W  = 4'd1,
    E  = 4'd2,
    N  = 4'd3,
    S  = 4'd4,
    RW = 4'd5,
    RE = 4'd6,
    RN = 4'd7,
    RS = 4'd8
  } bsg_mesh_dir_e;

  // Indexed by output direction; bit i set means input direction i may route there.
  localparam logic [4:0] mesh_xy_mask_lp [5] = '{5'b11110, 5'b00101, 5'b00011, 5'b10111, 5'b01111};
  localparam logic [4:0] mesh_yx_mask_lp [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10001, 5'b01001};

  localparam logic [8:0] ruche_xy_mask_lp [9] = '{9'h1FE, 9'h045, 9'h023, 9'h177, 9'h0EF,
                                                 9'h041, 9'h021, 9'h167, 9'h0E7};
  localparam logic [8:0] ruche_yx_mask_lp [9] = '{9'h1FE, 9'h1DD, 9'h1BB, 9'h111, 9'h089,
                                                 9'h1D9, 9'h1B9, 9'h101, 9'h081};

  function automatic int rr_ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_mesh_router_output_port_chk.sv
// Simulation-only protocol checks for one router output port.
module bsg_mesh_router_output_port_chk #(
  parameter int                     width_p      = 8,
  parameter int                     num_in_p     = 5,
  parameter logic [num_in_p-1:0]    input_mask_p = {num_in_p{1'b1}}
) (
  input logic                         clk_i,
  input logic                         reset_i,
  input logic [num_in_p-1:0]          reqs_i,
  input logic [num_in_p*width_p-1:0]  data_i,
  input logic [num_in_p-1:0]          yumi_o
);

  a_yumi_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
    $countones(yumi_o) <= 1);

  a_legal_route: assert property (@(posedge clk_i) disable iff (reset_i)
    (reqs_i & ~input_mask_p) == '0);

  for (genvar i = 0; i < num_in_p; i++) begin : g_stable
    a_req_stable: assert property (@(posedge clk_i) disable iff (reset_i)
      (reqs_i[i] && !yumi_o[i]) |=> (reqs_i[i] && $stable(data_i[i*width_p +: width_p])));
  end

endmodule

// File: rtl/bsg_mesh_router_rr_arb.sv
// Rotating-priority arbiter: one-hot grant searching upward from the pointer,
// pointer advances past the winner only when a grant is issued.
module bsg_mesh_router_rr_arb
  import bsg_mesh_router_output_port_pkg::*;
#(
  parameter int num_in_p = 5
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [num_in_p-1:0] req_i,
  input  logic                en_i,
  output logic [num_in_p-1:0] grant_o
);

  localparam int ptr_w_lp = rr_ptr_width(num_in_p);

  logic [ptr_w_lp-1:0] rr_ptr_r;
  logic [ptr_w_lp-1:0] gidx_s;
  logic [num_in_p-1:0] grant_s;
  logic                found_s;

  // Search from rr_ptr_r with explicit wrap since num_in_p need not be a power of two.
  always_comb begin
    int idx;
    idx     = 0;
    grant_s = '0;
    gidx_s  = '0;
    found_s = 1'b0;
    if (en_i & ~reset_i) begin
      for (int k = 0; k < num_in_p; k++) begin
        idx = int'(rr_ptr_r) + k;
        if (idx >= num_in_p) begin
          idx = idx - num_in_p;
        end else begin
          idx = idx;
        end
        if (!found_s && req_i[idx]) begin
          grant_s[idx] = 1'b1;
          gidx_s       = ptr_w_lp'(idx);
          found_s      = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      grant_s = '0;
    end
  end

  // Pointer register: moves one past the winner on grant.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_r <= '0;
    end else if (found_s) begin
      rr_ptr_r <= (gidx_s == ptr_w_lp'(num_in_p - 1)) ? '0 : gidx_s + ptr_w_lp'(1);
    end
  end

  assign grant_o = grant_s;

endmodule

// File: rtl/bsg_mesh_router_output_port.sv
// One mesh/ruche router output: round-robin arbitration over masked input
// requests feeding a single-entry output register with same-cycle refill.
module bsg_mesh_router_output_port
  import bsg_mesh_router_output_port_pkg::*;
#(
  parameter int                  width_p      = 8,
  parameter int                  num_in_p     = 5,
  parameter logic [num_in_p-1:0] input_mask_p = {num_in_p{1'b1}},
  parameter bit                  debug_p      = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [num_in_p-1:0]         reqs_i,
  input  logic [num_in_p*width_p-1:0] data_i,
  output logic [num_in_p-1:0]         yumi_o,
  output logic                        v_o,
  output logic [width_p-1:0]          data_o,
  input  logic                        ready_and_i
);

  logic                v_r;
  logic [width_p-1:0]  data_r;
  logic [num_in_p-1:0] eff_req_s;
  logic [num_in_p-1:0] grant_s;
  logic                enq_ready_s;
  logic [width_p-1:0]  data_next_s;

  assign eff_req_s   = reqs_i & input_mask_p;
  assign enq_ready_s = ~v_r | ready_and_i;

  bsg_mesh_router_rr_arb #(
    .num_in_p(num_in_p)
  ) arb (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .req_i  (eff_req_s),
    .en_i   (enq_ready_s),
    .grant_o(grant_s)
  );

  // One-hot AND-OR select of the winning flit.
  always_comb begin
    data_next_s = '0;
    for (int i = 0; i < num_in_p; i++) begin
      data_next_s = data_next_s | (data_i[i*width_p +: width_p] & {width_p{grant_s[i]}});
    end
  end

  // Output register; a grant refills it even while the current flit drains.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_r    <= 1'b0;
      data_r <= '0;
    end else if (|grant_s) begin
      v_r    <= 1'b1;
      data_r <= data_next_s;
    end else if (ready_and_i) begin
      v_r    <= 1'b0;
    end
  end

  assign yumi_o = grant_s;
  assign v_o    = v_r;
  assign data_o = data_r;

  if (debug_p) begin : g_chk
    bsg_mesh_router_output_port_chk #(
      .width_p     (width_p),
      .num_in_p    (num_in_p),
      .input_mask_p(input_mask_p)
    ) chk (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .reqs_i (reqs_i),
      .data_i (data_i),
      .yumi_o (yumi_o)
    );
  end

endmodule
